// File: rtl/sar_search4_pkg.sv
// Shared definitions for the 4-bit successive-approximation search engine.
//   sar_state_t   : FSM state encoding (IDLE/TEST/DONE)
//   SAR_W         : width of the searched value, trial word and result
//   SAR_MAX_STEPS : largest number of compares a single search can take
package sar_search4_pkg;

    localparam int         SAR_W         = 4;
    localparam logic [2:0] SAR_MAX_STEPS = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } sar_state_t;

endpackage

// File: rtl/sar_search4_comp4.sv
// 4-bit magnitude comparator, purely combinational.
//   a, b : unsigned operands
//   eq   : a == b
//   lt   : a <  b
module comp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eq,
    output logic       lt
);

    assign eq = (a == b);
    assign lt = (a <  b);

endmodule

// File: rtl/sar_search4.sv
// Successive-approximation search engine: finds a latched 4-bit target by
// binary search, deciding one trial bit per clock from comp4's eq/lt.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result/steps hold the last search
// TEST  | one compare/decision per clock, busy = 1
// DONE  | single-cycle done pulse, result/steps valid
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (aborts a search, no done)
//   start  : search request, only looked at in IDLE
//   target : value to search for, captured when start is accepted
//   busy   : high while in TEST
//   done   : one-cycle pulse when result/steps become valid
//   result : search result, held until the next accepted start
//   steps  : number of compares used (1..4), held with result
//
// EARLY_EXIT = 1 finishes on the first eq from comp4; 0 always does 4 compares.
module sar_search4
    import sar_search4_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SAR_W-1:0] target,
    output logic             busy,
    output logic             done,
    output logic [SAR_W-1:0] result,
    output logic [2:0]       steps
);

    sar_state_t       state_q, state_d;
    logic [SAR_W-1:0] target_q, target_d;
    logic [SAR_W-1:0] trial_q, trial_d;
    logic [SAR_W-1:0] result_q, result_d;
    logic [1:0]       k_q, k_d;
    logic [2:0]       steps_q, steps_d;

    logic [SAR_W-1:0] bit_k;
    logic [SAR_W-1:0] trial_dec;
    logic [2:0]       steps_inc;
    logic             eq;
    logic             lt;

    comp4 u_comp4 (
        .a  (target_q),
        .b  (trial_q),
        .eq (eq),
        .lt (lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= 2'd3;
            steps_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            k_q      <= k_d;
            steps_q  <= steps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        trial_d  = trial_q;
        result_d = result_q;
        k_d      = k_q;
        steps_d  = steps_q;

        bit_k     = 4'b0001 << k_q;
        // Trial too big: the bit under test cannot be part of the answer.
        trial_dec = lt ? (trial_q & ~bit_k) : trial_q;
        // Saturating increment; the compare count can never legitimately pass 4.
        steps_inc = (steps_q == SAR_MAX_STEPS) ? steps_q : steps_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = target;
                    trial_d  = 4'b1000;
                    k_d      = 2'd3;
                    steps_d  = 3'd0;
                    state_d  = TEST;
                end
            end
            TEST: begin
                steps_d = steps_inc;
                if (EARLY_EXIT && eq) begin
                    result_d = trial_q;
                    state_d  = DONE;
                end else if (k_q == 2'd0) begin
                    result_d = trial_dec;
                    state_d  = DONE;
                end else begin
                    // Next lower bit becomes the one under test.
                    trial_d = trial_dec | (bit_k >> 1);
                    k_d     = k_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q == TEST);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign steps  = steps_q;

endmodule
